ibex_tb_mem_arbiter: RTL and testbench

- Shares one single-port SRAM (ram_1p, 1-cycle read latency) between the Ibex instruction and data memory interfaces in the TestRIG/testbench top.
- Converts the Ibex req/gnt/rvalid protocol on both ports into RAM port accesses, arbitrates conflicts and routes each response back to its owner.
- Returns a bus error for any address outside the RAM window.
- Sits between ibex_top and the SRAM inside the simulation top wrapper.

---
 rtl/ibex_tb_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_ibex_tb_mem_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_tb_mem_arbiter.sv
// Shares one single-port, 1-cycle-latency SRAM between the Ibex instruction and data ports.
// Grants are combinational, responses come one cycle later, and out-of-window accesses return a bus error.
module ibex_tb_mem_arbiter #(
    parameter int unsigned Depth      = 16384,
    parameter logic [31:0] BaseAddr   = 32'h0000_0000,
    parameter bit          RoundRobin = 1'b1,
    parameter int unsigned AddrW      = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             instr_req_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    input  logic [31:0]      instr_addr_i,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,

    input  logic             data_req_i,
    output logic             data_gnt_o,
    output logic             data_rvalid_o,
    input  logic             data_we_i,
    input  logic [3:0]       data_be_i,
    input  logic [31:0]      data_addr_i,
    input  logic [31:0]      data_wdata_i,
    output logic [31:0]      data_rdata_o,
    output logic             data_err_o,

    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [3:0]       ram_be_o,
    output logic [AddrW-1:0] ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic             ram_rvalid_i,
    input  logic [31:0]      ram_rdata_i,

    output logic [15:0]      conflict_cnt_o
);

    localparam logic [32:0] WindowBytes = 33'(Depth) << 2;

    typedef enum logic {
        OwnerInstr = 1'b0,
        OwnerData  = 1'b1
    } owner_e;

    owner_e      last_grant;
    owner_e      resp_owner;
    logic        resp_pend;
    logic        resp_err;
    logic [15:0] conflict_cnt;

    logic        both_req;
    logic        grant_instr;
    logic        grant_data;
    logic        any_grant;
    logic        in_range;
    logic [31:0] sel_addr;
    logic [31:0] offset;

    function automatic logic [15:0] sat_inc16(input logic [15:0] cnt);
        return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    endfunction

    // Request stage: arbitration, range check and RAM strobe in the request cycle
    always_comb begin
        both_req    = instr_req_i & data_req_i;
        grant_instr = 1'b0;
        grant_data  = 1'b0;
        if (rst_ni) begin
            if (both_req) begin
                grant_data  = RoundRobin ? (last_grant == OwnerInstr) : 1'b1;
                grant_instr = ~grant_data;
            end else begin
                grant_instr = instr_req_i;
                grant_data  = data_req_i;
            end
        end
    end

    assign any_grant   = grant_instr | grant_data;
    assign instr_gnt_o = grant_instr;
    assign data_gnt_o  = grant_data;

    // Unsigned wrap makes addresses below BaseAddr land far outside the window
    assign sel_addr = grant_data ? data_addr_i : instr_addr_i;
    assign offset   = sel_addr - BaseAddr;
    assign in_range = {1'b0, offset} < WindowBytes;

    always_comb begin
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'h0;
        if (any_grant && in_range) begin
            ram_req_o  = 1'b1;
            ram_addr_o = offset[AddrW+1:2];
            if (grant_data) begin
                ram_we_o    = data_we_i;
                ram_be_o    = data_be_i;
                ram_wdata_o = data_wdata_i;
            end else begin
                ram_be_o = 4'hF;
            end
        end
    end

    // Response stage: remember who was granted and whether the access faulted
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_pend    <= 1'b0;
            resp_owner   <= OwnerInstr;
            resp_err     <= 1'b0;
            last_grant   <= OwnerInstr;
            conflict_cnt <= 16'h0;
        end else begin
            resp_pend <= any_grant;
            if (any_grant) begin
                resp_owner <= grant_data ? OwnerData : OwnerInstr;
                last_grant <= grant_data ? OwnerData : OwnerInstr;
                resp_err   <= ~in_range;
            end
            if (both_req) begin
                conflict_cnt <= sat_inc16(conflict_cnt);
            end
        end
    end

    assign instr_rvalid_o = resp_pend & (resp_owner == OwnerInstr);
    assign instr_err_o    = instr_rvalid_o & resp_err;
    assign instr_rdata_o  = (instr_rvalid_o & ~resp_err) ? ram_rdata_i : 32'h0;

    assign data_rvalid_o  = resp_pend & (resp_owner == OwnerData);
    assign data_err_o     = data_rvalid_o & resp_err;
    assign data_rdata_o   = (data_rvalid_o & ~resp_err) ? ram_rdata_i : 32'h0;

    assign conflict_cnt_o = conflict_cnt;

    // The RAM must answer exactly the in-window accesses granted last cycle
    ram_rvalid_check: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ram_rvalid_i == (resp_pend & ~resp_err));

endmodule

// File: tb/tb_ibex_tb_mem_arbiter.sv
// Bench for ibex_tb_mem_arbiter: instance 0 uses defaults, instance 1 a small window at 0x8000_0000
// with fixed data priority; both run against a word-level memory/arbitration reference model.
module tb_ibex_tb_mem_arbiter;

    localparam logic [31:0] BASE1 = 32'h8000_0000;
    localparam int DEP0 = 16384;
    localparam int DEP1 = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        ireq[2], dreq[2], dwe[2];
    logic [31:0] iaddr[2], daddr[2], dwdata[2];
    logic [3:0]  dbe[2];
    logic        igntw[2], irv[2], ierr[2], dgnt[2], drv[2], derr[2];
    logic        rreq[2], rwe[2], rrv[2];
    logic [31:0] irdata[2], drdata[2], rwdata[2], rrdata[2];
    logic [3:0]  rbe[2];
    logic [15:0] ccnt[2];
    logic [13:0] raddr0;
    logic [5:0]  raddr1;
    logic [31:0] mem[2][DEP0];

    // Reference model state
    bit          m_pend[2], m_owner[2], m_last[2], m_err[2], m_wr[2];
    logic [31:0] m_rdata[2];
    int          m_cnt[2];
    logic [31:0] sh[2][DEP0];
    bit          e_gi[2], e_gd[2], e_both[2], e_inr[2];
    logic [31:0] e_off[2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ibex_tb_mem_arbiter dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(ireq[0]), .instr_gnt_o(igntw[0]), .instr_rvalid_o(irv[0]),
        .instr_addr_i(iaddr[0]), .instr_rdata_o(irdata[0]), .instr_err_o(ierr[0]),
        .data_req_i(dreq[0]), .data_gnt_o(dgnt[0]), .data_rvalid_o(drv[0]),
        .data_we_i(dwe[0]), .data_be_i(dbe[0]), .data_addr_i(daddr[0]),
        .data_wdata_i(dwdata[0]), .data_rdata_o(drdata[0]), .data_err_o(derr[0]),
        .ram_req_o(rreq[0]), .ram_we_o(rwe[0]), .ram_be_o(rbe[0]), .ram_addr_o(raddr0),
        .ram_wdata_o(rwdata[0]), .ram_rvalid_i(rrv[0]), .ram_rdata_i(rrdata[0]),
        .conflict_cnt_o(ccnt[0])
    );

    ibex_tb_mem_arbiter #(.Depth(DEP1), .BaseAddr(BASE1), .RoundRobin(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_req_i(ireq[1]), .instr_gnt_o(igntw[1]), .instr_rvalid_o(irv[1]),
        .instr_addr_i(iaddr[1]), .instr_rdata_o(irdata[1]), .instr_err_o(ierr[1]),
        .data_req_i(dreq[1]), .data_gnt_o(dgnt[1]), .data_rvalid_o(drv[1]),
        .data_we_i(dwe[1]), .data_be_i(dbe[1]), .data_addr_i(daddr[1]),
        .data_wdata_i(dwdata[1]), .data_rdata_o(drdata[1]), .data_err_o(derr[1]),
        .ram_req_o(rreq[1]), .ram_we_o(rwe[1]), .ram_be_o(rbe[1]), .ram_addr_o(raddr1),
        .ram_wdata_o(rwdata[1]), .ram_rvalid_i(rrv[1]), .ram_rdata_i(rrdata[1]),
        .conflict_cnt_o(ccnt[1])
    );

    function automatic logic [31:0] init_word(int k, int i);
        if (k == 0 && i == 4) return 32'h0000_0013;
        if (k == 0 && i == 8) return 32'h0000_0000;
        return (32'(i) * 32'h9E37_79B9) ^ (32'(k) << 24);
    endfunction

    // RAM model: 1-cycle read latency, byte-enabled writes, contents restored on reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                rrv[k]    <= 1'b0;
                rrdata[k] <= 32'h0;
                for (int i = 0; i < DEP0; i++) mem[k][i] <= init_word(k, i);
            end
        end else begin
            rrv[0] <= rreq[0];
            rrv[1] <= rreq[1];
            if (rreq[0]) begin
                rrdata[0] <= mem[0][raddr0];
                for (int b = 0; b < 4; b++)
                    if (rwe[0] && rbe[0][b]) mem[0][raddr0][8*b +: 8] <= rwdata[0][8*b +: 8];
            end
            if (rreq[1]) begin
                rrdata[1] <= mem[1][raddr1];
                for (int b = 0; b < 4; b++)
                    if (rwe[1] && rbe[1][b]) mem[1][raddr1][8*b +: 8] <= rwdata[1][8*b +: 8];
            end
        end
    end

    function automatic logic [31:0] base_of(int k);
        return (k == 1) ? BASE1 : 32'h0;
    endfunction

    function automatic int dep_of(int k);
        return (k == 1) ? DEP1 : DEP0;
    endfunction

    function automatic logic [31:0] got_raddr(int k);
        return (k == 1) ? 32'(raddr1) : 32'(raddr0);
    endfunction

    function automatic logic [155:0] outs(int k);
        return {igntw[k], irv[k], irdata[k], ierr[k], dgnt[k], drv[k], drdata[k], derr[k],
                rreq[k], rwe[k], rbe[k], got_raddr(k), rwdata[k], ccnt[k]};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_owner[k] = 0; m_last[k] = 0; m_err[k] = 0; m_wr[k] = 0;
            m_rdata[k] = 32'h0; m_cnt[k] = 0;
            e_gi[k] = 0; e_gd[k] = 0; e_both[k] = 0; e_inr[k] = 0; e_off[k] = 32'h0;
            for (int i = 0; i < DEP0; i++) sh[k][i] = init_word(k, i);
        end
    endfunction

    // Who gets this cycle's grant and where it lands, from the arbitration rules
    function automatic void predict(int k);
        logic [31:0] a;
        e_both[k] = rst_n && ireq[k] && dreq[k];
        if (!rst_n) begin
            e_gi[k] = 0; e_gd[k] = 0;
        end else if (e_both[k]) begin
            e_gd[k] = (k == 0) ? (m_last[k] == 0) : 1'b1;
            e_gi[k] = !e_gd[k];
        end else begin
            e_gi[k] = ireq[k]; e_gd[k] = dreq[k];
        end
        a = e_gd[k] ? daddr[k] : iaddr[k];
        e_off[k] = a - base_of(k);
        e_inr[k] = {32'h0, e_off[k]} < 64'(dep_of(k)) * 64'd4;
    endfunction

    // Apply the effect of the cycle that just ended (inputs are still those of that cycle)
    function automatic void commit(int k);
        int w;
        if (e_gi[k] || e_gd[k]) begin
            m_pend[k] = 1; m_owner[k] = e_gd[k]; m_last[k] = e_gd[k];
            m_err[k] = !e_inr[k]; m_wr[k] = e_gd[k] && dwe[k];
            m_rdata[k] = 32'h0;
            if (e_inr[k]) begin
                w = int'(e_off[k] >> 2);
                m_rdata[k] = sh[k][w];
                for (int b = 0; b < 4; b++)
                    if (m_wr[k] && dbe[k][b]) sh[k][w][8*b +: 8] = dwdata[k][8*b +: 8];
            end
        end else begin
            m_pend[k] = 0;
        end
        if (e_both[k] && m_cnt[k] < 65535) m_cnt[k]++;
    endfunction

    task automatic drive(input int k, input bit ir, input logic [31:0] ia, input bit dr,
                         input bit we, input logic [3:0] be, input logic [31:0] da,
                         input logic [31:0] wd);
        @(negedge clk);
        commit(0); commit(1);
        for (int j = 0; j < 2; j++) begin
            ireq[j] = 0; iaddr[j] = 32'h0; dreq[j] = 0; dwe[j] = 0;
            dbe[j] = 4'h0; daddr[j] = 32'h0; dwdata[j] = 32'h0;
        end
        ireq[k] = ir; iaddr[k] = ia; dreq[k] = dr; dwe[k] = we;
        dbe[k] = be; daddr[k] = da; dwdata[k] = wd;
        #1;
        predict(0); predict(1);
    endtask

    task automatic idle(input int k);
        drive(k, 0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        for (int j = 0; j < 2; j++) begin ireq[j] = 0; dreq[j] = 0; dwe[j] = 0; end
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_addr(int k);
        int r = $urandom_range(0, 9);
        if (r == 0) return base_of(k) - 32'(4 * $urandom_range(1, 8));
        if (r == 1) return base_of(k) + 32'(dep_of(k) * 4) + 32'($urandom_range(0, 1000));
        return base_of(k) + 32'($urandom_range(0, 255));
    endfunction

    task automatic test_reset();
        for (int j = 0; j < 2; j++) begin
            ireq[j] = 1; dreq[j] = 1; dwe[j] = 0; dbe[j] = 4'hF;
            iaddr[j] = base_of(j); daddr[j] = base_of(j); dwdata[j] = 32'h0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (outs(k) !== '0) begin errors++; $display("FAIL reset_hold k=%0d got=%h exp=0", k, outs(k)); end
        end
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin ireq[j] = 0; dreq[j] = 0; end
        rst_n = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++; if (outs(k) !== '0) begin errors++; $display("FAIL reset_release k=%0d got=%h exp=0", k, outs(k)); end
        end
    endtask

    task automatic test_instr_fetch();
        drive(0, 1, 32'h0000_0010, 0, 0, 4'h0, 32'h0, 32'h0);
        checks++; if (igntw[0] !== 1'b1) begin errors++; $display("FAIL fetch_gnt got=%b exp=1", igntw[0]); end
        checks++; if (got_raddr(0) !== 32'd4) begin errors++; $display("FAIL fetch_addr got=%0d exp=4", got_raddr(0)); end
        checks++; if ({rreq[0], rwe[0], rbe[0], rwdata[0]} !== {1'b1, 1'b0, 4'hF, 32'h0}) begin
            errors++; $display("FAIL fetch_ram req/we/be/wdata got=%b/%b/%h/%h exp=1/0/f/0", rreq[0], rwe[0], rbe[0], rwdata[0]); end
        idle(0);
        checks++; if ({irv[0], ierr[0], drv[0]} !== 3'b100) begin errors++; $display("FAIL fetch_rvalid irv/err/drv got=%b%b%b exp=100", irv[0], ierr[0], drv[0]); end
        checks++; if (irdata[0] !== 32'h0000_0013) begin errors++; $display("FAIL fetch_rdata got=%h exp=00000013", irdata[0]); end
    endtask

    task automatic test_data_write_read();
        drive(0, 0, 32'h0, 1, 1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF);
        checks++; if ({dgnt[0], rreq[0], rwe[0], rbe[0]} !== {1'b1, 1'b1, 1'b1, 4'h3}) begin
            errors++; $display("FAIL wr_ram gnt/req/we/be got=%b/%b/%b/%h exp=1/1/1/3", dgnt[0], rreq[0], rwe[0], rbe[0]); end
        checks++; if (got_raddr(0) !== 32'd8) begin errors++; $display("FAIL wr_addr got=%0d exp=8", got_raddr(0)); end
        checks++; if (rwdata[0] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_wdata got=%h exp=deadbeef", rwdata[0]); end
        drive(0, 0, 32'h0, 1, 0, 4'hF, 32'h0000_0020, 32'h0);
        checks++; if ({drv[0], derr[0], dgnt[0], rwe[0]} !== 4'b1010) begin
            errors++; $display("FAIL b2b_wr_resp rv/err/gnt/we got=%b%b%b%b exp=1010", drv[0], derr[0], dgnt[0], rwe[0]); end
        idle(0);
        checks++; if (drv[0] !== 1'b1) begin errors++; $display("FAIL rd_rvalid got=%b exp=1", drv[0]); end
        checks++; if (drdata[0] !== 32'h0000_BEEF) begin errors++; $display("FAIL rd_rdata got=%h exp=0000beef", drdata[0]); end
    endtask

    task automatic test_conflict_rr();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            drive(0, 1, 32'h0000_0100, 1, 0, 4'hF, 32'h0000_0200, 32'h0);
            checks++; if ({dgnt[0], igntw[0]} !== ((n % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_grant n=%0d dgnt/igntw got=%b%b", n, dgnt[0], igntw[0]); end
            if (n > 0) begin
                checks++; if ({drv[0], irv[0]} !== ((n % 2 == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL rr_rvalid n=%0d drv/irv got=%b%b", n, drv[0], irv[0]); end
            end
        end
        idle(0);
        checks++; if ({drv[0], irv[0]} !== 2'b01) begin errors++; $display("FAIL rr_last_rvalid drv/irv got=%b%b exp=01", drv[0], irv[0]); end
        checks++; if (ccnt[0] !== 16'd4) begin errors++; $display("FAIL rr_conflict_cnt got=%0d exp=4", ccnt[0]); end
    endtask

    task automatic test_conflict_fixed();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            drive(1, 1, BASE1 + 32'h10, 1, 0, 4'hF, BASE1 + 32'h20, 32'h0);
            checks++; if ({dgnt[1], igntw[1]} !== 2'b10) begin
                errors++; $display("FAIL fixed_grant n=%0d dgnt/igntw got=%b%b exp=10", n, dgnt[1], igntw[1]); end
        end
        drive(1, 1, BASE1 + 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
        checks++; if ({igntw[1], drv[1]} !== 2'b11) begin errors++; $display("FAIL fixed_instr_later igntw/drv got=%b%b exp=11", igntw[1], drv[1]); end
        checks++; if (ccnt[1] !== 16'd4) begin errors++; $display("FAIL fixed_conflict_cnt got=%0d exp=4", ccnt[1]); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] addrs[2];
        addrs[0] = 32'h0001_0000;
        addrs[1] = BASE1 - 32'd4;
        for (int k = 0; k < 2; k++) begin
            drive(k, 0, 32'h0, 1, 0, 4'hF, addrs[k], 32'h0);
            checks++; if ({dgnt[k], rreq[k]} !== 2'b10) begin
                errors++; $display("FAIL oor_grant k=%0d gnt/ram_req got=%b%b exp=10", k, dgnt[k], rreq[k]); end
            idle(k);
            checks++; if ({drv[k], derr[k], drdata[k], irv[k]} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
                errors++; $display("FAIL oor_resp k=%0d rv/err/rdata/irv got=%b/%b/%h/%b exp=1/1/0/0", k, drv[k], derr[k], drdata[k], irv[k]); end
        end
    endtask

    task automatic test_random();
        bit xr, ir, dr, we;
        logic [31:0] exp_rd;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 1500; c++) begin
                ir = ($urandom_range(0, 9) < 6);
                dr = ($urandom_range(0, 9) < 6);
                we = 1'($urandom_range(0, 1));
                drive(k, ir, rand_addr(k), dr, we, 4'($urandom_range(1, 15)), rand_addr(k), $urandom);
                xr = (e_gi[k] || e_gd[k]) && e_inr[k];
                checks++; if ({igntw[k], dgnt[k]} !== {e_gi[k], e_gd[k]}) begin
                    errors++; $display("FAIL rnd_grant k=%0d c=%0d got=%b%b exp=%b%b", k, c, igntw[k], dgnt[k], e_gi[k], e_gd[k]); end
                checks++; if ({rreq[k], rwe[k], rbe[k]} !== {xr, xr && e_gd[k] && dwe[k], xr ? (e_gd[k] ? dbe[k] : 4'hF) : 4'h0}) begin
                    errors++; $display("FAIL rnd_ram_ctl k=%0d c=%0d got=%b/%b/%h", k, c, rreq[k], rwe[k], rbe[k]); end
                checks++; if (got_raddr(k) !== (xr ? (e_off[k] >> 2) : 32'h0)) begin
                    errors++; $display("FAIL rnd_ram_addr k=%0d c=%0d got=%h exp=%h", k, c, got_raddr(k), xr ? (e_off[k] >> 2) : 32'h0); end
                checks++; if (rwdata[k] !== ((xr && e_gd[k]) ? dwdata[k] : 32'h0)) begin
                    errors++; $display("FAIL rnd_ram_wdata k=%0d c=%0d got=%h", k, c, rwdata[k]); end
                checks++; if ({irv[k], drv[k]} !== {m_pend[k] && !m_owner[k], m_pend[k] && m_owner[k]}) begin
                    errors++; $display("FAIL rnd_rvalid k=%0d c=%0d got=%b%b exp=%b%b", k, c, irv[k], drv[k], m_pend[k] && !m_owner[k], m_pend[k] && m_owner[k]); end
                checks++; if ({ierr[k], derr[k]} !== {m_pend[k] && !m_owner[k] && m_err[k], m_pend[k] && m_owner[k] && m_err[k]}) begin
                    errors++; $display("FAIL rnd_err k=%0d c=%0d got=%b%b", k, c, ierr[k], derr[k]); end
                exp_rd = (m_pend[k] && !m_err[k]) ? m_rdata[k] : 32'h0;
                if (!(m_pend[k] && m_wr[k])) begin
                    checks++; if (irdata[k] !== (m_owner[k] ? 32'h0 : exp_rd) || drdata[k] !== (m_owner[k] ? exp_rd : 32'h0)) begin
                        errors++; $display("FAIL rnd_rdata k=%0d c=%0d got=%h/%h exp_owner_data=%h", k, c, irdata[k], drdata[k], exp_rd); end
                end
                checks++; if (ccnt[k] !== 16'(m_cnt[k])) begin
                    errors++; $display("FAIL rnd_conflict_cnt k=%0d c=%0d got=%0d exp=%0d", k, c, ccnt[k], m_cnt[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 32'h0000_0010, 0, 0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        rst_n = 0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++; if (outs(k) !== '0) begin errors++; $display("FAIL midrst_hold n=%0d k=%0d got=%h exp=0", n, k, outs(k)); end
            end
            @(negedge clk);
        end
        ireq[0] = 0;
        rst_n = 1;
        for (int n = 0; n < 3; n++) begin
            idle(0);
            for (int k = 0; k < 2; k++) begin
                checks++; if (outs(k) !== '0) begin errors++; $display("FAIL midrst_after n=%0d k=%0d got=%h exp=0", n, k, outs(k)); end
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int n = 0; n < 70000; n++)
            drive(0, 1, 32'h0000_0040, 1, 0, 4'hF, 32'h0000_0080, 32'h0);
        checks++; if (ccnt[0] !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt got=%h exp=ffff", ccnt[0]); end
        checks++; if (ccnt[1] !== 16'h0) begin errors++; $display("FAIL sat_other_cnt got=%h exp=0", ccnt[1]); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_instr_fetch();
        test_data_write_read();
        test_conflict_rr();
        test_conflict_fixed();
        test_out_of_range();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
